// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_if
// Brief    : Requester (I/D) and memory-side bundle for memory_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    // Instruction-fetch requester
    logic                      i_valid;
    logic                      i_ready;
    logic                      i_wen;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic [DATA_WIDTH-1:0]     i_wdata;
    logic [DATA_WIDTH/8-1:0]   i_wmask;
    logic                      i_rvalid;
    logic [DATA_WIDTH-1:0]     i_rdata;

    // Load/store requester
    logic                      d_valid;
    logic                      d_ready;
    logic                      d_wen;
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH/8-1:0]   d_wmask;
    logic                      d_rvalid;
    logic [DATA_WIDTH-1:0]     d_rdata;

    // Shared single-port memory
    logic                      mem_ready;
    logic                      mem_valid;
    logic                      mem_wen;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wmask;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    // Arbiter view
    modport slave (
        input  i_valid, i_wen, i_addr, i_wdata, i_wmask,
        output i_ready, i_rvalid, i_rdata,
        input  d_valid, d_wen, d_addr, d_wdata, d_wmask,
        output d_ready, d_rvalid, d_rdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    // Environment view (requesters plus memory)
    modport master (
        output i_valid, i_wen, i_addr, i_wdata, i_wmask,
        input  i_ready, i_rvalid, i_rdata,
        output d_valid, d_wen, d_addr, d_wdata, d_wmask,
        input  d_ready, d_rvalid, d_rdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Round-robin I/D arbiter owning one outstanding memory transaction.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    memory_arbiter_if.slave  bus
);
    localparam int                      c_mask_width = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0]   c_zero_addr  = '0;
    localparam logic [DATA_WIDTH-1:0]   c_zero_data  = '0;
    localparam logic [c_mask_width-1:0] c_zero_mask  = '0;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_busy_i = 2'd1;
    localparam logic [1:0] c_st_busy_d = 2'd2;

    localparam logic c_port_i = 1'b0;
    localparam logic c_port_d = 1'b1;

    logic [1:0] r_state;
    logic       r_last_grant;

    logic w_resp_i;
    logic w_resp_d;
    logic w_can_issue;
    logic w_any_valid;
    logic w_grant_d;
    logic w_accept;

    // rst gates issue so every output is 0 while reset is asserted
    always_comb begin
        w_resp_i    = bus.mem_rvalid && (r_state == c_st_busy_i);
        w_resp_d    = bus.mem_rvalid && (r_state == c_st_busy_d);
        w_can_issue = !rst && bus.mem_ready
                      && ((r_state == c_st_idle) || bus.mem_rvalid);
        w_any_valid = bus.i_valid || bus.d_valid;
        w_grant_d   = bus.d_valid && (!bus.i_valid || (r_last_grant == c_port_i));
        w_accept    = w_can_issue && w_any_valid;
    end

    assign bus.i_ready   = w_accept && !w_grant_d;
    assign bus.d_ready   = w_accept && w_grant_d;
    assign bus.mem_valid = w_accept;

    always_comb begin
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = c_zero_addr;
        bus.mem_wdata = c_zero_data;
        bus.mem_wmask = c_zero_mask;
        if (w_accept) begin
            if (w_grant_d) begin
                bus.mem_wen   = bus.d_wen;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.mem_wmask = bus.d_wmask;
            end else begin
                bus.mem_wen   = bus.i_wen;
                bus.mem_addr  = bus.i_addr;
                bus.mem_wdata = bus.i_wdata;
                bus.mem_wmask = bus.i_wmask;
            end
        end
    end

    assign bus.i_rvalid = w_resp_i;
    assign bus.d_rvalid = w_resp_d;
    assign bus.i_rdata  = w_resp_i ? bus.mem_rdata : c_zero_data;
    assign bus.d_rdata  = w_resp_d ? bus.mem_rdata : c_zero_data;

    // A response cycle may also accept the next request, chaining BUSY states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_last_grant <= c_port_i;
        end else if (w_accept) begin
            r_state      <= w_grant_d ? c_st_busy_d : c_st_busy_i;
            r_last_grant <= w_grant_d ? c_port_d : c_port_i;
        end else if (w_resp_i || w_resp_d) begin
            r_state      <= c_st_idle;
        end
    end
endmodule
`default_nettype wire
